// File: rtl/jt49_bus_multi.sv
// AY-style BDIR/BC2/BC1 bus front-end sharing one CPU bus among NCHIPS JT49 cores.
// Optional JT49_BUS_FIFO_EN: deep write FIFO instead of a single holding register.
module jt49_bus_multi #(
  parameter int NCHIPS     = 2,
  parameter int CHIP_BASE  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  bdir,
  input  logic                  bc2,
  input  logic                  bc1,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  fifo_full,
  output logic                  overflow,
  output logic [3:0]            core_addr,
  output logic [7:0]            core_din,
  output logic [NCHIPS-1:0]     core_cs_n,
  output logic [NCHIPS-1:0]     core_wr_n,
  input  logic [8*NCHIPS-1:0]   core_dout
);

  localparam int SELW = (NCHIPS > 1) ? $clog2(NCHIPS) : 1;

  typedef struct packed {
    logic [SELW-1:0] chip;
    logic [3:0]      addr;
    logic [7:0]      data;
  } wr_t;

  typedef enum logic {IDLE, STROBE} st_t;

  st_t             st;
  logic            prev_wr;
  logic            addr_valid;
  logic [SELW-1:0] sel;
  logic [3:0]      laddr;

  logic            is_latch;
  logic            is_read;
  logic            is_write;
  logic            push_req;
  logic            do_push;
  logic            do_pop;
  logic            read_ok;
  logic            empty;
  logic            full;
  wr_t             head;
  wr_t             new_e;

  logic [4:0]      off;
  logic            hit;
  logic [SELW-1:0] hit_k;
  logic [7:0]      cd [NCHIPS];

  for (genvar g = 0; g < NCHIPS; g++) begin : g_cd
    assign cd[g] = core_dout[8*g +: 8];
  end

  always_comb begin
    is_latch = 1'b0;
    is_read  = 1'b0;
    is_write = 1'b0;
    unique case ({bdir, bc2, bc1})
      3'b001, 3'b100, 3'b111: is_latch = 1'b1;
      3'b011:                 is_read  = 1'b1;
      3'b110:                 is_write = 1'b1;
      default: ;
    endcase
  end

  // Negative offset (sign bit set) means din is below CHIP_BASE
  assign off   = {1'b0, din[7:4]} - 5'(CHIP_BASE);
  assign hit   = !off[4] && ({1'b0, off[3:0]} < 5'(NCHIPS));
  assign hit_k = off[SELW-1:0];

  assign new_e    = '{chip: sel, addr: laddr, data: din};
  assign push_req = is_write && !prev_wr && addr_valid;
  assign do_pop   = (st == IDLE) && !empty && clk_en;
  assign read_ok  = is_read && (st == IDLE) && !do_pop;
  assign fifo_full = full;

`ifdef JT49_BUS_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wp;
  logic [AW:0] rp;
  wr_t         mem [FIFO_DEPTH];

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push_req && (!full || do_pop);
  assign head    = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= new_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end
`else
  logic occ;
  wr_t  hold;
  logic unused_depth;

  assign unused_depth = ^FIFO_DEPTH;
  assign empty   = !occ;
  assign full    = occ;
  assign do_push = push_req && !occ;
  assign head    = hold;

  // Slot stays busy until the strobe cycle has finished
  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 1'b0;
      hold <= '0;
    end else if (do_push) begin
      occ  <= 1'b1;
      hold <= new_e;
    end else if (st == STROBE) begin
      occ  <= 1'b0;
    end
  end
`endif

  function automatic logic [NCHIPS-1:0] chip_oh(input logic [SELW-1:0] k);
    chip_oh    = '0;
    chip_oh[k] = 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      prev_wr    <= 1'b0;
      addr_valid <= 1'b0;
      sel        <= '0;
      laddr      <= '0;
      overflow   <= 1'b0;
      dout       <= 8'hFF;
      core_addr  <= '0;
      core_din   <= '0;
      core_cs_n  <= '1;
      core_wr_n  <= '1;
    end else begin
      prev_wr <= is_write;
      if (is_latch) begin
        addr_valid <= hit;
        if (hit) begin
          sel   <= hit_k;
          laddr <= din[3:0];
        end
      end
      if (push_req && !do_push) overflow <= 1'b1;
      unique case (st)
        IDLE:   if (do_pop) st <= STROBE;
        STROBE: st <= IDLE;
      endcase
      core_cs_n <= '1;
      core_wr_n <= '1;
      if (do_pop) begin
        core_addr <= head.addr;
        core_din  <= head.data;
        core_cs_n <= ~chip_oh(head.chip);
        core_wr_n <= ~chip_oh(head.chip);
      end else if (read_ok) begin
        core_addr <= laddr;
        if (addr_valid) begin
          core_cs_n <= ~chip_oh(sel);
          dout      <= cd[sel];
        end else begin
          dout      <= 8'hFF;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt49_bus_multi.sv
// Randomised bench for jt49_bus_multi against a queue-based bus model.
// Model capacity follows JT49_BUS_FIFO_EN.
module tb_jt49_bus_multi;

  localparam int NCH  = 2;
  localparam int BASE = 0;
`ifdef JT49_BUS_FIFO_EN
  localparam int CAP  = 4;
  localparam bit FIFO = 1'b1;
`else
  localparam int CAP  = 1;
  localparam bit FIFO = 1'b0;
`endif

  localparam logic [2:0] INACT = 3'b000;
  localparam logic [2:0] LATCH = 3'b001;
  localparam logic [2:0] READ  = 3'b011;
  localparam logic [2:0] WRITE = 3'b110;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clk_en = 1'b0;
  logic           bdir = 1'b0;
  logic           bc2 = 1'b0;
  logic           bc1 = 1'b0;
  logic [7:0]     din = 8'h00;
  logic [7:0]     dout;
  logic           fifo_full;
  logic           overflow;
  logic [3:0]     core_addr;
  logic [7:0]     core_din;
  logic [NCH-1:0] core_cs_n;
  logic [NCH-1:0] core_wr_n;
  logic [7:0]     cv [NCH];
  logic [8*NCH-1:0] core_dout;

  assign core_dout = {cv[1], cv[0]};

  always #5 clk = ~clk;

  jt49_bus_multi #(
    .NCHIPS(NCH),
    .CHIP_BASE(BASE),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .bdir(bdir),
    .bc2(bc2),
    .bc1(bc1),
    .din(din),
    .dout(dout),
    .fifo_full(fifo_full),
    .overflow(overflow),
    .core_addr(core_addr),
    .core_din(core_din),
    .core_cs_n(core_cs_n),
    .core_wr_n(core_wr_n),
    .core_dout(core_dout)
  );

  int n_chk = 0;
  int n_fail = 0;
  int obs_strobes = 0;
  bit cv_fix = 1'b0;

  // Reference model state
  logic [15:0]    m_q [$];
  bit             m_strobe;
  bit             m_prevwr;
  bit             m_av;
  int             m_sel;
  logic [3:0]     m_laddr;
  bit             m_ovf;
  logic [7:0]     m_dout;
  logic [3:0]     m_caddr;
  logic [7:0]     m_cdin;
  logic [NCH-1:0] m_cs;
  logic [NCH-1:0] m_wr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_strobe = 0;
    m_prevwr = 0;
    m_av     = 0;
    m_sel    = 0;
    m_laddr  = 4'h0;
    m_ovf    = 0;
    m_dout   = 8'hFF;
    m_caddr  = 4'h0;
    m_cdin   = 8'h00;
    m_cs     = '1;
    m_wr     = '1;
  endtask

  task automatic model_edge(input logic [2:0] b, input logic [7:0] d,
                            input logic ce, input logic r);
    bit lat, rd, wr, pop, push;
    int occ, hi;
    logic [15:0] e;
    if (r) begin
      model_reset();
      return;
    end
    lat  = (b == 3'b001) || (b == 3'b100) || (b == 3'b111);
    rd   = (b == READ);
    wr   = (b == WRITE);
    pop  = !m_strobe && (m_q.size() > 0) && ce;
    push = wr && !m_prevwr && m_av;
    occ  = FIFO ? m_q.size() - int'(pop) : m_q.size() + int'(m_strobe);
    m_cs = '1;
    m_wr = '1;
    if (pop) begin
      e       = m_q.pop_front();
      m_caddr = e[11:8];
      m_cdin  = e[7:0];
      m_cs    = ~(NCH'(1) << e[15:12]);
      m_wr    = m_cs;
    end else if (rd && !m_strobe) begin
      m_caddr = m_laddr;
      if (m_av) begin
        m_cs   = ~(NCH'(1) << m_sel);
        m_dout = cv[m_sel];
      end else begin
        m_dout = 8'hFF;
      end
    end
    if (push) begin
      if (occ < CAP) m_q.push_back({4'(m_sel), m_laddr, d});
      else m_ovf = 1;
    end
    if (lat) begin
      hi   = int'(d[7:4]);
      m_av = (hi >= BASE) && (hi < BASE + NCH);
      if (m_av) begin
        m_sel   = hi - BASE;
        m_laddr = d[3:0];
      end
    end
    m_prevwr = wr;
    m_strobe = pop;
  endtask

  task automatic step(input logic [2:0] b, input logic [7:0] d,
                      input logic ce, input logic r);
    int occ;
    @(negedge clk);
    {bdir, bc2, bc1} = b;
    din    = d;
    clk_en = ce;
    rst    = r;
    if (!cv_fix) begin
      cv[0] = 8'($urandom);
      cv[1] = 8'($urandom);
    end
    @(posedge clk);
    model_edge(b, d, ce, r);
    #1;
    occ = FIFO ? m_q.size() : m_q.size() + int'(m_strobe);
    if (core_wr_n != '1) obs_strobes++;
    chk("cs_n", 32'(core_cs_n), 32'(m_cs));
    chk("wr_n", 32'(core_wr_n), 32'(m_wr));
    chk("core_addr", 32'(core_addr), 32'(m_caddr));
    chk("core_din", 32'(core_din), 32'(m_cdin));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("fifo_full", 32'(fifo_full), 32'(occ == CAP));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n, input logic ce);
    for (int i = 0; i < n; i++) step(INACT, 8'h00, ce, 1'b0);
  endtask

  initial begin
    int s0;
    logic [2:0] rb;
    logic [7:0] rd8;
    cv[0] = 8'h00;
    cv[1] = 8'h00;
    model_reset();
    step(INACT, 8'h00, 1'b0, 1'b1);
    step(INACT, 8'h00, 1'b0, 1'b1);
    chk("rst_dout", 32'(dout), 32'hFF);
    chk("rst_cs", 32'(core_cs_n), 32'h3);
    idle(2, 1'b1);

    // Single strobe from a long WRITE
    s0 = obs_strobes;
    step(LATCH, 8'h13, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(WRITE, 8'hA5, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("t1_strobes", 32'(obs_strobes - s0), 32'd1);

    // Unmapped chip: no strobe, read returns FF
    s0 = obs_strobes;
    step(LATCH, 8'h27, 1'b1, 1'b0);
    step(WRITE, 8'h55, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(READ, 8'h00, 1'b1, 1'b0);
    step(READ, 8'h00, 1'b1, 1'b0);
    chk("t2_strobes", 32'(obs_strobes - s0), 32'd0);
    chk("t2_dout", 32'(dout), 32'hFF);

    // Fill with clk_en low, then drain
    step(LATCH, 8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(WRITE, 8'(8'h30 + i), 1'b0, 1'b0);
      step(INACT, 8'h00, 1'b0, 1'b0);
    end
    chk("t3_full", 32'(fifo_full), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    s0 = obs_strobes;
    idle(10, 1'b1);
    chk("t3_strobes", 32'(obs_strobes - s0), 32'(CAP));
    chk("t3_empty", 32'(fifo_full), 32'd0);

    // Read chip 0 register
    cv_fix = 1'b1;
    cv[0]  = 8'h3C;
    cv[1]  = 8'hC3;
    step(LATCH, 8'h05, 1'b1, 1'b0);
    step(READ, 8'h00, 1'b1, 1'b0);
    chk("t4_dout", 32'(dout), 32'h3C);
    chk("t4_cs", 32'(core_cs_n), 32'h2);
    step(READ, 8'h00, 1'b1, 1'b0);
    cv_fix = 1'b0;

    // Reset discards queued writes
    step(LATCH, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(WRITE, 8'(8'h60 + i), 1'b0, 1'b0);
      step(INACT, 8'h00, 1'b0, 1'b0);
    end
    step(INACT, 8'h00, 1'b1, 1'b1);
    s0 = obs_strobes;
    idle(8, 1'b1);
    chk("t5_strobes", 32'(obs_strobes - s0), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);

    // Two writes one clock apart
    s0 = obs_strobes;
    step(LATCH, 8'h14, 1'b1, 1'b0);
    step(WRITE, 8'h11, 1'b1, 1'b0);
    step(INACT, 8'h00, 1'b1, 1'b0);
    step(WRITE, 8'h22, 1'b1, 1'b0);
    idle(6, 1'b1);
    chk("t6_strobes", 32'(obs_strobes - s0), 32'(CAP == 1 ? 1 : 2));
    chk("t6_ovf", 32'(overflow), 32'(CAP == 1));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rb  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rb = WRITE;
      rd8 = 8'($urandom);
      rd8[7:4] = 4'($urandom_range(0, 3));
      step(rb, rd8, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
